// File: rtl/freeze_pkg.sv
// Shared encodings for the freeze controller: FSM states, config register layout
// and the default config register address.
package freeze_pkg;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    FREEZE  = 2'd1,
    HOLDOFF = 2'd2,
    FORCE   = 2'd3
  } state_e;

  localparam int unsigned CFG_MASK_LSB  = 0;
  localparam int unsigned CFG_EXT_BIT   = 8;
  localparam int unsigned CFG_FORCE_BIT = 9;
  localparam int unsigned CFG_HOLD_LSB  = 16;
  localparam int unsigned CFG_HOLD_W    = 8;
  localparam int unsigned CFG_CLR_BIT   = 31;

  localparam logic [6:0] CFG_ADDR_DEFAULT = 7'd80;

  // active_src is a fixed 3-bit field, enough for up to 8 sources
  localparam int unsigned SRC_IDX_W = 3;

endpackage

// File: rtl/freeze_arbiter.sv
// Lowest-index priority pick over eligible request edges, plus the extend-mode
// compare of the winner's duration against the decremented freeze counter.
module freeze_arbiter
  import freeze_pkg::*;
#(
  parameter int unsigned CNT_W   = 16,
  parameter int unsigned NUM_SRC = 2
) (
  input  logic [NUM_SRC-1:0]       req_edge,
  input  logic [NUM_SRC-1:0]       mask,
  input  logic [NUM_SRC*CNT_W-1:0] stop_time,
  input  logic [CNT_W-1:0]         remaining,
  output logic                     hit_c,
  output logic [SRC_IDX_W-1:0]     win_idx_c,
  output logic [CNT_W-1:0]         win_time_c,
  output logic                     ext_wins_c
);

  // Scan from the top so the lowest eligible index is the last one written
  always_comb begin
    hit_c      = 1'b0;
    win_idx_c  = '0;
    win_time_c = '0;
    for (int i = int'(NUM_SRC) - 1; i >= 0; i--) begin
      if (req_edge[i] && mask[i] && (stop_time[i*CNT_W +: CNT_W] != '0)) begin
        hit_c      = 1'b1;
        win_idx_c  = SRC_IDX_W'(i);
        win_time_c = stop_time[i*CNT_W +: CNT_W];
      end
    end
  end

  assign ext_wins_c = hit_c && (win_time_c > (remaining - CNT_W'(1)));

endmodule

// File: rtl/freeze_controller.sv
// Multi-source freeze controller: arbitrates stop requests into a registered
// clock-enable for the DSP domain, with extend/drop, holdoff, force and status.
module freeze_controller
  import freeze_pkg::*;
#(
  parameter int unsigned CNT_W    = 16,
  parameter int unsigned NUM_SRC  = 2,
  parameter int unsigned HOLD_W   = 8,
  parameter logic [6:0]  CFG_ADDR = CFG_ADDR_DEFAULT
) (
  input  logic                     clock,
  input  logic                     reset_n,
  input  logic                     serial_strobe,
  input  logic [6:0]               serial_addr,
  input  logic [31:0]              serial_data,
  input  logic [NUM_SRC-1:0]       stop_req,
  input  logic [NUM_SRC*CNT_W-1:0] stop_time,
  output logic                     clk_en,
  output logic                     frozen,
  output logic [SRC_IDX_W-1:0]     active_src,
  output logic [CNT_W-1:0]         remaining,
  output logic [15:0]              freeze_count,
  output logic                     dropped
);

  localparam int unsigned FC_W = 16;

  state_e               state_q, state_d;
  logic [NUM_SRC-1:0]   mask_q;
  logic                 ext_q, force_q, clr_q;
  logic [HOLD_W-1:0]    hold_len_q, hold_q, hold_d;
  logic [NUM_SRC-1:0]   req_q;
  logic [CNT_W-1:0]     rem_d;
  logic [SRC_IDX_W-1:0] src_d;
  logic [FC_W-1:0]      fc_d;
  logic                 drop_d, clk_en_d, frozen_d;

  logic                 cfg_wr_c, hit_c, ext_wins_c;
  logic [SRC_IDX_W-1:0] win_idx_c;
  logic [CNT_W-1:0]     win_time_c;
  logic [NUM_SRC-1:0]   req_edge_c;
  logic                 unused_c;

  assign cfg_wr_c   = serial_strobe && (serial_addr == CFG_ADDR);
  assign req_edge_c = stop_req & ~req_q;
  assign unused_c   = ^serial_data;

  // Config register; clear is a one-cycle pulse and is never stored
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      mask_q     <= '0;
      ext_q      <= 1'b0;
      force_q    <= 1'b0;
      hold_len_q <= '0;
      clr_q      <= 1'b0;
      req_q      <= '0;
    end else begin
      clr_q <= 1'b0;
      req_q <= stop_req;
      if (cfg_wr_c) begin
        mask_q     <= serial_data[CFG_MASK_LSB +: NUM_SRC];
        ext_q      <= serial_data[CFG_EXT_BIT];
        force_q    <= serial_data[CFG_FORCE_BIT];
        hold_len_q <= HOLD_W'(serial_data[CFG_HOLD_LSB +: CFG_HOLD_W]);
        clr_q      <= serial_data[CFG_CLR_BIT];
      end
    end
  end

  freeze_arbiter #(
    .CNT_W   (CNT_W),
    .NUM_SRC (NUM_SRC)
  ) u_arb (
    .req_edge   (req_edge_c),
    .mask       (mask_q),
    .stop_time  (stop_time),
    .remaining  (remaining),
    .hit_c      (hit_c),
    .win_idx_c  (win_idx_c),
    .win_time_c (win_time_c),
    .ext_wins_c (ext_wins_c)
  );

  // Next state and next values of every registered output
  always_comb begin
    state_d = state_q;
    rem_d   = remaining;
    src_d   = active_src;
    hold_d  = hold_q;
    fc_d    = freeze_count;
    drop_d  = dropped;
    if (clr_q) drop_d = 1'b0;

    unique case (state_q)
      IDLE: begin
        if (force_q) begin
          state_d = FORCE;
        end else if (hit_c) begin
          state_d = FREEZE;
          rem_d   = win_time_c;
          src_d   = win_idx_c;
        end
      end
      FREEZE: begin
        if (force_q) begin
          state_d = FORCE;
          rem_d   = '0;
        end else if (ext_q && ext_wins_c) begin
          rem_d = win_time_c;
          src_d = win_idx_c;
        end else begin
          if (hit_c && !ext_q) drop_d = 1'b1;
          rem_d = remaining - CNT_W'(1);
          if (remaining == CNT_W'(1)) begin
            state_d = (hold_len_q != '0) ? HOLDOFF : IDLE;
            hold_d  = hold_len_q;
            if (freeze_count != '1) fc_d = freeze_count + FC_W'(1);
          end
        end
      end
      HOLDOFF: begin
        if (force_q) begin
          state_d = FORCE;
          rem_d   = '0;
        end else begin
          if (hit_c) drop_d = 1'b1;
          hold_d = hold_q - HOLD_W'(1);
          if (hold_q == HOLD_W'(1)) state_d = IDLE;
        end
      end
      FORCE: begin
        if (!force_q) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase

    // Clear beats a completion in the same cycle; a drop still beats clear
    if (clr_q) fc_d = '0;

    frozen_d = (state_d == FREEZE) || (state_d == FORCE);
    clk_en_d = !frozen_d;
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_q      <= IDLE;
      remaining    <= '0;
      active_src   <= '0;
      hold_q       <= '0;
      freeze_count <= '0;
      dropped      <= 1'b0;
      clk_en       <= 1'b1;
      frozen       <= 1'b0;
    end else begin
      state_q      <= state_d;
      remaining    <= rem_d;
      active_src   <= src_d;
      hold_q       <= hold_d;
      freeze_count <= fc_d;
      dropped      <= drop_d;
      clk_en       <= clk_en_d;
      frozen       <= frozen_d;
    end
  end

endmodule

// File: tb/tb_freeze_controller.sv
// Directed bench for freeze_controller: expected freeze lengths are queued when a
// request is driven and compared against the measured clk_en low window.
module tb_freeze_controller;

  localparam int unsigned CNT_W   = 16;
  localparam int unsigned NUM_SRC = 2;

  logic                     clock;
  logic                     reset_n;
  logic                     serial_strobe;
  logic [6:0]               serial_addr;
  logic [31:0]              serial_data;
  logic [NUM_SRC-1:0]       stop_req;
  logic [NUM_SRC*CNT_W-1:0] stop_time;
  logic                     clk_en;
  logic                     frozen;
  logic [2:0]               active_src;
  logic [CNT_W-1:0]         remaining;
  logic [15:0]              freeze_count;
  logic                     dropped;

  int checks   = 0;
  int failures = 0;
  int exp_q[$];
  int n;
  int lowc;

  freeze_controller #(
    .CNT_W    (CNT_W),
    .NUM_SRC  (NUM_SRC),
    .HOLD_W   (8),
    .CFG_ADDR (7'd80)
  ) dut (
    .clock         (clock),
    .reset_n       (reset_n),
    .serial_strobe (serial_strobe),
    .serial_addr   (serial_addr),
    .serial_data   (serial_data),
    .stop_req      (stop_req),
    .stop_time     (stop_time),
    .clk_en        (clk_en),
    .frozen        (frozen),
    .active_src    (active_src),
    .remaining     (remaining),
    .freeze_count  (freeze_count),
    .dropped       (dropped)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic step();
    @(posedge clock);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic sb_check(input string tag, input int obs);
    int exp;
    if (exp_q.size() == 0) begin
      checks++;
      failures++;
      $error("FAIL %s observed=%0d expected=<empty scoreboard>", tag, obs);
    end else begin
      exp = exp_q.pop_front();
      chk(tag, 32'(obs), 32'(exp));
    end
  endtask

  task automatic wr_cfg(input logic [31:0] data);
    serial_strobe = 1'b1;
    serial_addr   = 7'd80;
    serial_data   = data;
    step();
    serial_strobe = 1'b0;
    serial_data   = '0;
  endtask

  // Counts consecutive frozen cycles starting at the current observation
  task automatic count_low(output int cnt);
    cnt = 0;
    while (clk_en === 1'b0 && cnt < 300) begin
      cnt++;
      step();
    end
  endtask

  initial begin
    reset_n       = 1'b0;
    serial_strobe = 1'b0;
    serial_addr   = '0;
    serial_data   = '0;
    stop_req      = '0;
    stop_time     = '0;
    step();
    step();
    chk("rst_clk_en", clk_en, 1);
    chk("rst_frozen", frozen, 0);
    chk("rst_active_src", active_src, 0);
    chk("rst_remaining", remaining, 0);
    chk("rst_freeze_count", freeze_count, 0);
    chk("rst_dropped", dropped, 0);
    reset_n = 1'b1;
    step();

    // Basic 5-cycle freeze from source 0
    wr_cfg(32'h0000_0001);
    stop_time = {16'd0, 16'd5};
    stop_req  = 2'b01;
    exp_q.push_back(5);
    step();
    stop_req = 2'b00;
    chk("t1_latency_clk_en", clk_en, 0);
    chk("t1_first_remaining", remaining, 5);
    count_low(n);
    sb_check("t1_freeze_len", n);
    chk("t1_freeze_count", freeze_count, 1);

    // Drop mode: src1 edge during third frozen cycle is rejected
    wr_cfg(32'h0000_0003);
    stop_time = {16'd20, 16'd10};
    stop_req  = 2'b01;
    exp_q.push_back(10);
    step();
    stop_req = 2'b00;
    step();
    step();
    stop_req = 2'b10;
    count_low(n);
    sb_check("t2_drop_len", n + 2);
    chk("t2_dropped", dropped, 1);
    chk("t2_active_src", active_src, 0);
    stop_req = 2'b00;

    // Clear pulse plus extend mode
    wr_cfg(32'h8000_0103);
    step();
    chk("clr_dropped", dropped, 0);
    chk("clr_freeze_count", freeze_count, 0);

    stop_req = 2'b01;
    exp_q.push_back(23);
    step();
    stop_req = 2'b00;
    step();
    step();
    stop_req = 2'b10;
    count_low(n);
    sb_check("t3_extend_len", n + 2);
    chk("t3_active_src", active_src, 1);
    chk("t3_dropped", dropped, 0);
    chk("t3_freeze_count", freeze_count, 1);
    stop_req = 2'b00;

    // Holdoff of 4 cycles after a 3-cycle freeze
    wr_cfg(32'h0004_0001);
    stop_time = {16'd0, 16'd3};
    stop_req  = 2'b01;
    exp_q.push_back(3);
    step();
    stop_req = 2'b00;
    count_low(n);
    sb_check("t4_first_len", n);
    step();
    stop_req = 2'b01;
    step();
    chk("t4_holdoff_clk_en", clk_en, 1);
    chk("t4_holdoff_dropped", dropped, 1);
    stop_req = 2'b00;
    step();
    step();
    stop_req = 2'b01;
    exp_q.push_back(3);
    step();
    stop_req = 2'b00;
    chk("t4_after_holdoff_clk_en", clk_en, 0);
    count_low(n);
    sb_check("t4_second_len", n);
    chk("t4_freeze_count", freeze_count, 3);
    for (int i = 0; i < 5; i++) step();

    // Force mid-freeze, held 12 cycles
    wr_cfg(32'h0000_0001);
    stop_time = {16'd0, 16'd10};
    stop_req  = 2'b01;
    step();
    stop_req = 2'b00;
    chk("t5_start_remaining", remaining, 10);
    step();
    step();
    step();
    chk("t5_pre_force_remaining", remaining, 7);
    wr_cfg(32'h0000_0201);
    chk("t5_force_edge_clk_en", clk_en, 0);
    exp_q.push_back(12);
    lowc = 0;
    for (int i = 0; i < 12; i++) begin
      if (clk_en === 1'b0 && frozen === 1'b1) lowc++;
      step();
    end
    sb_check("t5_force_low_cycles", lowc);
    chk("t5_force_remaining", remaining, 0);
    wr_cfg(32'h0000_0001);
    chk("t5_release_still_frozen", clk_en, 0);
    step();
    chk("t5_idle_clk_en", clk_en, 1);
    chk("t5_idle_frozen", frozen, 0);
    chk("t5_freeze_count", freeze_count, 3);

    // Zero duration is a no-op, not a drop
    wr_cfg(32'h8000_0003);
    step();
    chk("t7_clr_dropped", dropped, 0);
    chk("t7_clr_freeze_count", freeze_count, 0);
    stop_time = {16'd6, 16'd0};
    stop_req  = 2'b01;
    step();
    stop_req = 2'b00;
    chk("t7_zero_clk_en", clk_en, 1);
    step();
    chk("t7_zero_dropped", dropped, 0);

    // Simultaneous edges: lowest index wins
    stop_time = {16'd6, 16'd4};
    stop_req  = 2'b11;
    exp_q.push_back(4);
    step();
    stop_req = 2'b00;
    chk("t6_active_src", active_src, 0);
    chk("t6_remaining", remaining, 4);
    count_low(n);
    sb_check("t6_len", n);
    chk("t6_freeze_count", freeze_count, 1);

    // Asynchronous reset in the middle of a freeze
    stop_time = {16'd0, 16'd10};
    stop_req  = 2'b01;
    step();
    stop_req = 2'b00;
    chk("t8_frozen_before_reset", clk_en, 0);
    step();
    #2;
    reset_n = 1'b0;
    #1;
    chk("t8_async_clk_en", clk_en, 1);
    chk("t8_async_frozen", frozen, 0);
    chk("t8_async_remaining", remaining, 0);
    chk("t8_async_active_src", active_src, 0);
    chk("t8_async_freeze_count", freeze_count, 0);
    chk("t8_async_dropped", dropped, 0);
    step();
    reset_n = 1'b1;
    step();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/freeze_controller.md
Name: freeze_controller

Overview:
- Parametrised successor to the single-source top-level "timestop" freeze counter.
- Arbitrates stop requests from NUM_SRC sources, each with its own programmable duration.
- Produces a clock-enable for the DSP clock domain, so the clock itself is never gated.
- Adds an extend/drop policy, a post-freeze holdoff window, a software force-freeze and sticky status, all configured through one serial setting register.

Parameters:
- CNT_W, 16: width of stop_time fields and the freeze down-counter.
- NUM_SRC, 2: number of independent stop-request sources (1..8).
- HOLD_W, 8: width of the holdoff counter.
- CFG_ADDR, 7'd80: serial_addr that writes the config register.

Ports:
- clock  in  1  DSP clock (64 MHz domain).
- reset_n  in  1  asynchronous, active-low reset.
- serial_strobe  in  1  one-cycle write strobe from the serial/register bus.
- serial_addr  in  7  register address.
- serial_data  in  32  register write data.
- stop_req  in  NUM_SRC  per-source stop request, level-sampled each cycle.
- stop_time  in  NUM_SRC*CNT_W  per-source duration; source i occupies bits [i*CNT_W +: CNT_W].
- clk_en  out  1  high = downstream DSP advances; low = frozen.
- frozen  out  1  high in FREEZE or FORCE.
- active_src  out  3  index of the source owning the current freeze.
- remaining  out  CNT_W  current down-counter value.
- freeze_count  out  16  number of completed freezes, saturating.
- dropped  out  1  sticky: a request was rejected.

Behaviour:
- Reset (async assert, sync release) sets:
  - state=IDLE, clk_en=1, frozen=0, active_src=0, remaining=0, freeze_count=0, dropped=0.
  - Config register = 0: all sources masked, drop mode, no force, holdoff 0.
- Config register (written when serial_strobe && serial_addr==CFG_ADDR, takes effect the next cycle):
  - [7:0] source enable mask; bits at or above NUM_SRC are ignored.
  - [8] extend mode.
  - [9] force.
  - [23:16] holdoff length (low HOLD_W bits).
  - [31] clear: self-clearing pulse that zeroes dropped and freeze_count.
- Eligible request: stop_req[i] && mask[i] && stop_time_i != 0. A zero duration is a no-op and never counts as dropped.
- Arbitration: lowest eligible index wins.
- IDLE:
  - force=1 -> FORCE.
  - Else any eligible request -> FREEZE; remaining<=stop_time_winner, active_src<=winner.
  - clk_en goes low the cycle after the request is sampled (1-cycle latency, registered output).
- FREEZE:
  - clk_en=0 and remaining decrements each cycle.
  - The DSP is frozen for exactly stop_time cycles.
  - When remaining==1 and it decrements to 0: go to HOLDOFF if holdoff!=0, else IDLE; freeze_count increments (saturating at 16'hFFFF).
- Requests arriving during FREEZE, per eligible source:
  - Extend mode: remaining <= max(remaining-1, stop_time_i); active_src updates only if the new value wins.
  - Drop mode: request ignored, dropped<=1.
  - A request from active_src itself while held high is not a new request; requests are edge-qualified, a rising edge of stop_req[i].
- HOLDOFF:
  - clk_en=1; a counter runs for holdoff cycles.
  - Eligible request edges set dropped=1 and are discarded.
  - Exits to IDLE at terminal count.
- FORCE:
  - clk_en=0, remaining holds, frozen=1.
  - Returns to IDLE the cycle after force clears; freeze_count is not incremented.
- Force asserted during FREEZE or HOLDOFF: immediate transition to FORCE. The in-progress freeze is abandoned, not counted, and remaining is cleared.
- Simultaneous clear and a dropped event in the same cycle: the drop wins (dropped=1, freeze_count=0).
- Mask bit cleared mid-freeze: the current freeze completes normally.
- Reset mid-FREEZE: clk_en=1 immediately (async).

Decomposition:
- Package freeze_pkg holds:
  - state encoding: IDLE, FREEZE, HOLDOFF, FORCE.
  - config bit-field position constants: CFG_MASK_LSB, CFG_EXT_BIT, CFG_FORCE_BIT, CFG_HOLD_LSB, CFG_CLR_BIT.
  - default CFG_ADDR.
- Sub-module freeze_arbiter: combinational lowest-index priority encoder over eligible edge-qualified requests, with an extend-mode max-compare output. The top holds the FSM, counters and config register.

Test Plan:
- Mask=01, stop_time0=5, pulse stop_req[0] -> clk_en low exactly 5 cycles starting 1 cycle after the request; freeze_count=1; remaining counts 5..1.
- Drop mode, src0 time 10 active, src1 edge at cycle 3 with time 20 -> freeze lasts 10 cycles, dropped=1, active_src=0.
- Extend mode, same stimulus -> clk_en low 3+20=23 cycles total, active_src=1, dropped=0.
- Holdoff=4, freeze ends, src0 edge 2 cycles later -> no freeze, dropped=1; an edge 5 cycles after the end freezes normally.
- Force set mid-freeze (remaining=7), clear after 12 cycles -> clk_en low throughout, freeze_count unchanged, IDLE one cycle after clear.
- Simultaneous src0/src1 edges, both eligible -> src0 wins; stop_time=0 on an eligible source -> no freeze, dropped stays 0; reset_n low mid-freeze -> clk_en=1 asynchronously, all status zero.
